output_port_allocator: RTL

- Wormhole output-port allocator for one router output port.
- Shares the port between N_INPUTS input ports using round-robin arbitration with packet locking: the grant is held from the head flit to the tail flit.
- Gates forwarding on a downstream credit counter.
- Sits between the per-input buffers and the output crossbar mux select; grant_o drives the mux one-hot.

---
 rtl/noc_alloc_pkg.sv | 14 +
 rtl/output_port_allocator_rr_pick.sv | 32 +++
 rtl/output_port_allocator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for NoC output-port allocators.
package noc_alloc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/output_port_allocator_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] index_o,
  output logic          valid_o
);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        onehot_o      = '0;
        onehot_o[idx] = 1'b1;
        index_o       = IW'(idx);
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin arbitration with packet lock
// from head to tail, forwarding gated by a downstream credit counter.
module output_port_allocator
  import noc_alloc_pkg::*;
#(
  parameter  int N_INPUTS     = 4,
  parameter  int CREDIT_DEPTH = 4,
  localparam int CW           = credit_w(CREDIT_DEPTH)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [N_INPUTS-1:0] flit_valid_i,
  input  logic [N_INPUTS-1:0] flit_tail_i,
  output logic [N_INPUTS-1:0] flit_ready_o,
  output logic [N_INPUTS-1:0] grant_o,
  output logic                out_valid_o,
  output logic                out_tail_o,
  input  logic                credit_return_i,
  output logic [CW-1:0]       credits_o,
  output logic                busy_o,
  output logic                credit_err_o
);

  localparam int IW = $clog2(N_INPUTS);

  alloc_state_e        state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [N_INPUTS-1:0] grant_q, grant_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic                err_q, err_d;

  logic [N_INPUTS-1:0] pick_onehot;
  logic [IW-1:0]       pick_index;
  logic                pick_valid;
  logic                transfer;
  logic                tail_xfer;

  rr_pick #(
    .N (N_INPUTS)
  ) u_rr_pick (
    .req_i    (flit_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_index),
    .valid_o  (pick_valid)
  );

  // grant_q is non-zero only while LOCKED, so it gates transfers by itself.
  assign transfer  = (|(grant_q & flit_valid_i)) && (credits_q != '0);
  assign tail_xfer = transfer && (|(grant_q & flit_tail_i));

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      credits_q <= CW'(CREDIT_DEPTH);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOCKED;
          owner_d = pick_index;
          grant_d = pick_onehot;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == IW'(N_INPUTS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // A return at full count is dropped and flagged rather than wrapping.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({transfer, credit_return_i})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CW'(CREDIT_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + 1'b1;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    grant_o      = grant_q;
    busy_o       = (state_q == LOCKED);
    flit_ready_o = grant_q & {N_INPUTS{transfer}};
    out_valid_o  = transfer;
    out_tail_o   = tail_xfer;
    credits_o    = credits_q;
    credit_err_o = err_q;
  end

endmodule
